// File: rtl/dot_seq_ctrl.sv
// ---------------------------------------------------------------------------
// dot_seq_ctrl
//
// Sequencer for an external dot_nxn multiply-accumulate unit. On a start
// request it walks the term selector from 0 to arraySize-1 (asserting clear
// on the first term so the accumulator restarts), waits macLatency cycles for
// the last term to reach z, captures z into result and holds it with
// result_valid until the consumer accepts it with result_ready.
//
// Parameters
//   arraySize    : number of vector terms per dot product
//   addressWidth : selector width, 2**addressWidth >= arraySize
//   zBits        : accumulator / result width
//   macLatency   : cycles from a term on the selector to its effect on z (>= 1)
//
// Ports
//   clk          : in  clock, rising edge active
//   rst          : in  asynchronous active-high reset
//   start        : in  request one dot product (honoured in IDLE only)
//   busy         : out high whenever the FSM is not IDLE
//   selector     : out term index to dot_nxn
//   clear        : out restart accumulation with the current term
//   z            : in  accumulator output from dot_nxn
//   result       : out captured dot product
//   result_valid : out result holds a completed dot product
//   result_ready : in  consumer accepts result
// ---------------------------------------------------------------------------
module dot_seq_ctrl #(
    parameter int arraySize    = 4,
    parameter int addressWidth = 2,
    parameter int zBits        = 28,
    parameter int macLatency   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic [addressWidth-1:0] selector,
    output logic                    clear,
    input  logic [zBits-1:0]        z,
    output logic [zBits-1:0]        result,
    output logic                    result_valid,
    input  logic                    result_ready
);

    // Latency counter only needs to reach macLatency-1.
    localparam int LAT_W = (macLatency > 1) ? $clog2(macLatency) : 1;

    localparam logic [addressWidth-1:0] TERM_LAST = addressWidth'(arraySize - 1);
    localparam logic [addressWidth-1:0] TERM_ZERO = addressWidth'(0);
    localparam logic [addressWidth-1:0] TERM_ONE  = addressWidth'(1);
    localparam logic [LAT_W-1:0]        LAT_LAST  = LAT_W'(macLatency - 1);
    localparam logic [LAT_W-1:0]        LAT_ZERO  = LAT_W'(0);
    localparam logic [LAT_W-1:0]        LAT_ONE   = LAT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [addressWidth-1:0] r_term;
    logic [LAT_W-1:0]        r_lat;
    logic                    r_busy;
    logic [addressWidth-1:0] r_selector;
    logic                    r_clear;
    logic [zBits-1:0]        r_result;
    logic                    r_result_valid;

    // Sequencer FSM; all outputs are registered and change together with the
    // state so that selector/clear are aligned with the FEED cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_term         <= TERM_ZERO;
            r_lat          <= LAT_ZERO;
            r_busy         <= 1'b0;
            r_selector     <= TERM_ZERO;
            r_clear        <= 1'b0;
            r_result       <= {zBits{1'b0}};
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= FEED;
                        r_term     <= TERM_ZERO;
                        r_busy     <= 1'b1;
                        r_selector <= TERM_ZERO;
                        // First term restarts the accumulator.
                        r_clear    <= 1'b1;
                    end else begin
                        r_busy     <= 1'b0;
                        r_selector <= TERM_ZERO;
                        r_clear    <= 1'b0;
                    end
                end

                FEED: begin
                    r_clear <= 1'b0;
                    // Compare against the last term explicitly so a non-power
                    // of two arraySize never lets the counter run past it.
                    if (r_term == TERM_LAST) begin
                        r_state    <= DRAIN;
                        r_term     <= TERM_ZERO;
                        r_selector <= TERM_ZERO;
                        r_lat      <= LAT_ZERO;
                    end else begin
                        r_term     <= r_term + TERM_ONE;
                        r_selector <= r_term + TERM_ONE;
                    end
                end

                DRAIN: begin
                    // z reflects the last term by the final DRAIN cycle.
                    if (r_lat == LAT_LAST) begin
                        r_state        <= HOLD;
                        r_lat          <= LAT_ZERO;
                        r_result       <= z;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_lat <= r_lat + LAT_ONE;
                    end
                end

                HOLD: begin
                    // start is deliberately ignored here, even alongside
                    // result_ready; the consumer re-issues it from IDLE.
                    if (result_ready) begin
                        r_state        <= IDLE;
                        r_busy         <= 1'b0;
                        r_result_valid <= 1'b0;
                    end else begin
                        r_result_valid <= 1'b1;
                    end
                end

                default: begin
                    r_state        <= IDLE;
                    r_term         <= TERM_ZERO;
                    r_lat          <= LAT_ZERO;
                    r_busy         <= 1'b0;
                    r_selector     <= TERM_ZERO;
                    r_clear        <= 1'b0;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign selector     = r_selector;
    assign clear        = r_clear;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dot_seq_ctrl
//
// Self-checking bench for dot_seq_ctrl. Two instances share clk/rst:
//   u_dut1 : default parameters, driven by a latency-1 MAC model
//   u_dut2 : arraySize=3, macLatency=3, driven by a latency-3 MAC model
// Expected dot products are computed from the operand vectors and pushed to
// a per-instance queue at start; they are popped when result_valid appears.
// ---------------------------------------------------------------------------
module tb_dot_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start1 = 1'b0, ready1 = 1'b0, start2 = 1'b0, ready2 = 1'b0;
    logic        busy1, clear1, rv1, busy2, clear2, rv2;
    logic [1:0]  sel1, sel2;
    logic [27:0] z1 = 28'd0, z2 = 28'd0, res1, res2;

    int va[4];
    int vb[4];
    int wa[3];
    int wb[3];

    logic [27:0] q1[$];
    logic [27:0] q2[$];

    int checks = 0;
    int errors = 0;
    logic sel2_hit3 = 1'b0;

    dot_seq_ctrl u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .selector(sel1),
        .clear(clear1), .z(z1), .result(res1), .result_valid(rv1),
        .result_ready(ready1)
    );

    dot_seq_ctrl #(.arraySize(3), .addressWidth(2), .zBits(28), .macLatency(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .selector(sel2),
        .clear(clear2), .z(z2), .result(res2), .result_valid(rv2),
        .result_ready(ready2)
    );

    // Latency-1 MAC model: term on selector shows up in z next cycle.
    always @(posedge clk) begin
        if (clear1) z1 <= 28'(va[sel1] * vb[sel1]);
        else        z1 <= z1 + 28'(va[sel1] * vb[sel1]);
    end

    // Latency-3 MAC model: two product pipeline stages, then accumulate.
    logic [27:0] p1 = 28'd0, p2 = 28'd0;
    logic        c1 = 1'b0, c2 = 1'b0;
    always @(posedge clk) begin
        p1 <= (sel2 < 2'd3) ? 28'(wa[sel2] * wb[sel2]) : 28'd0;
        c1 <= clear2;
        p2 <= p1;
        c2 <= c1;
        if (c2) z2 <= p2;
        else    z2 <= z2 + p2;
        if (sel2 == 2'd3) sel2_hit3 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] dot1();
        int s = 0;
        for (int i = 0; i < 4; i++) s += va[i] * vb[i];
        return 28'(s);
    endfunction

    function automatic logic [27:0] dot2();
        int s = 0;
        for (int i = 0; i < 3; i++) s += wa[i] * wb[i];
        return 28'(s);
    endfunction

    // Wait (bounded) for result_valid on u_dut1, check latency and result,
    // then complete the handshake. n0 is the cycle index already reached.
    task automatic finish_op1(input int n0, input int lat_exp);
        int n = n0;
        logic [27:0] exp;
        while (!rv1 && n < 40) begin
            tick();
            n++;
        end
        chk("dut1_latency", 64'(n), 64'(lat_exp));
        chk("dut1_rv", 64'(rv1), 64'd1);
        if (q1.size() > 0) begin
            exp = q1.pop_front();
            chk("dut1_result", 64'(res1), 64'(exp));
        end else begin
            chk("dut1_scoreboard_empty", 64'd1, 64'd0);
        end
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        chk("dut1_rv_after_ready", 64'(rv1), 64'd0);
        chk("dut1_busy_after_ready", 64'(busy1), 64'd0);
    endtask

    task automatic run_op1();
        q1.push_back(dot1());
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        finish_op1(1, 6);
    endtask

    initial begin
        logic [27:0] exp;
        int n;

        // Asynchronous reset state, before any clock edge.
        #1;
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_sel", 64'(sel1), 64'd0);
        chk("rst_clear", 64'(clear1), 64'd0);
        chk("rst_result", 64'(res1), 64'd0);
        chk("rst_rv", 64'(rv1), 64'd0);
        chk("rst_busy2", 64'(busy2), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reference operation: (1,2,3,4).(5,6,7,8) = 70, start in cycle 0.
        va = '{1, 2, 3, 4};
        vb = '{5, 6, 7, 8};
        q1.push_back(dot1());
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("feed_sel", 64'(sel1), 64'(c));
            chk("feed_clear", 64'(clear1), (c == 0) ? 64'd1 : 64'd0);
            chk("feed_busy", 64'(busy1), 64'd1);
            chk("feed_rv", 64'(rv1), 64'd0);
            tick();
        end
        chk("drain_busy", 64'(busy1), 64'd1);
        chk("drain_sel", 64'(sel1), 64'd0);
        chk("drain_clear", 64'(clear1), 64'd0);
        chk("drain_rv", 64'(rv1), 64'd0);
        tick();
        chk("hold_rv_cycle6", 64'(rv1), 64'd1);
        exp = q1.pop_front();
        chk("hold_result", 64'(res1), 64'(exp));

        // Stall in HOLD for 10 cycles with stray start pulses.
        for (int i = 0; i < 10; i++) begin
            start1 = (i % 3 == 0) ? 1'b1 : 1'b0;
            tick();
            chk("stall_rv", 64'(rv1), 64'd1);
            chk("stall_result", 64'(res1), 64'd70);
            chk("stall_busy", 64'(busy1), 64'd1);
            chk("stall_sel", 64'(sel1), 64'd0);
        end

        // start together with result_ready: handshake only, start dropped.
        start1 = 1'b1;
        ready1 = 1'b1;
        tick();
        start1 = 1'b0;
        ready1 = 1'b0;
        chk("hs_rv", 64'(rv1), 64'd0);
        chk("hs_busy", 64'(busy1), 64'd0);
        chk("hs_result_kept", 64'(res1), 64'd70);
        tick();
        chk("hs_start_dropped", 64'(busy1), 64'd0);

        // Back-to-back operation, clear must wipe the previous sum.
        va = '{2, 2, 2, 2};
        vb = '{3, 3, 3, 3};
        run_op1();

        // Wide operands exercise the upper result bits.
        va = '{4000, 3000, 2000, 1000};
        vb = '{5000, 6000, 7000, 8000};
        run_op1();

        // start held high: handshake returns to IDLE, next edge relaunches.
        va = '{1, 1, 2, 3};
        vb = '{5, 8, 13, 21};
        q1.push_back(dot1());
        start1 = 1'b1;
        tick();
        n = 1;
        while (!rv1 && n < 40) begin
            tick();
            n++;
        end
        chk("held_latency", 64'(n), 64'd6);
        exp = q1.pop_front();
        chk("held_result", 64'(res1), 64'(exp));
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        chk("held_idle_busy", 64'(busy1), 64'd0);
        q1.push_back(dot1());
        tick();
        chk("held_relaunch_busy", 64'(busy1), 64'd1);
        chk("held_relaunch_clear", 64'(clear1), 64'd1);
        start1 = 1'b0;
        finish_op1(1, 6);

        // Reset in the third FEED cycle aborts the operation.
        va = '{9, 9, 9, 9};
        vb = '{9, 9, 9, 9};
        q1.push_back(dot1());
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        chk("abort_pre_sel", 64'(sel1), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy1), 64'd0);
        chk("abort_sel", 64'(sel1), 64'd0);
        chk("abort_clear", 64'(clear1), 64'd0);
        chk("abort_result", 64'(res1), 64'd0);
        chk("abort_rv", 64'(rv1), 64'd0);
        q1.delete();
        tick();
        tick();
        rst = 1'b0;
        va = '{3, 1, 4, 1};
        vb = '{5, 9, 2, 6};
        q1.push_back(dot1());
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("post_rst_busy", 64'(busy1), 64'd1);
        chk("post_rst_clear", 64'(clear1), 64'd1);
        finish_op1(1, 6);

        // Second instance: arraySize=3, macLatency=3.
        wa = '{1, 2, 3};
        wb = '{4, 5, 6};
        q2.push_back(dot2());
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("d2_feed_sel", 64'(sel2), 64'(c));
            chk("d2_feed_clear", 64'(clear2), (c == 0) ? 64'd1 : 64'd0);
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            chk("d2_drain_busy", 64'(busy2), 64'd1);
            chk("d2_drain_sel", 64'(sel2), 64'd0);
            chk("d2_drain_rv", 64'(rv2), 64'd0);
            tick();
        end
        chk("d2_rv_s7", 64'(rv2), 64'd1);
        exp = q2.pop_front();
        chk("d2_result", 64'(res2), 64'(exp));
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        chk("d2_rv_after_ready", 64'(rv2), 64'd0);

        // Second op on instance 2: no residue from the first.
        wa = '{7, 0, 1};
        wb = '{2, 9, 3};
        q2.push_back(dot2());
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 1;
        while (!rv2 && n < 40) begin
            tick();
            n++;
        end
        chk("d2_latency", 64'(n), 64'd7);
        exp = q2.pop_front();
        chk("d2_result2", 64'(res2), 64'(exp));
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        chk("d2_sel_never_3", 64'(sel2_hit3), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
